// File: rtl/vga_pkg.sv
// Shared timing defaults and colour definitions for the 640x480 VGA scan path.
package vga_pkg;

    localparam logic [9:0] DEF_H_ACTIVE = 10'd640;
    localparam logic [9:0] DEF_H_FP     = 10'd16;
    localparam logic [9:0] DEF_H_SYNC   = 10'd96;
    localparam logic [9:0] DEF_H_BP     = 10'd48;
    localparam logic [9:0] DEF_V_ACTIVE = 10'd480;
    localparam logic [9:0] DEF_V_FP     = 10'd10;
    localparam logic [9:0] DEF_V_SYNC   = 10'd2;
    localparam logic [9:0] DEF_V_BP     = 10'd33;

    localparam logic [9:0] H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam logic [9:0] V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [2:0] color_t;

    localparam int COLOR_R = 2;
    localparam int COLOR_G = 1;
    localparam int COLOR_B = 0;

    localparam color_t COLOR_BLACK = 3'b000;
    localparam color_t COLOR_WHITE = 3'b111;
    localparam color_t COLOR_RED   = 3'b100;
    localparam color_t COLOR_BLUE  = 3'b001;

endpackage

// File: rtl/scan_counter.sv
// Modulo-TOTAL scan counter; wrap flags the enabled cycle that returns the count to zero.
module scan_counter
    import vga_pkg::*;
#(
    parameter logic [9:0] TOTAL = H_TOTAL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] count,
    output logic       wrap
);

    logic [9:0] count_q;
    logic [9:0] count_d;
    logic       at_last;

    assign at_last = (count_q == TOTAL - 10'd1);
    assign wrap    = en && at_last;
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = at_last ? '0 : count_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_scan_driver.sv
// Raster scan driver: x/y coordinate generation, blanking mask and one-stage RGB/sync alignment.
// Optional monitor-alignment border enabled by defining VGA_SCAN_BORDER_EN.
module vga_scan_driver
    import vga_pkg::*;
#(
    parameter logic [9:0] H_ACTIVE = DEF_H_ACTIVE,
    parameter logic [9:0] H_FP     = DEF_H_FP,
    parameter logic [9:0] H_SYNC   = DEF_H_SYNC,
    parameter logic [9:0] H_BP     = DEF_H_BP,
    parameter logic [9:0] V_ACTIVE = DEF_V_ACTIVE,
    parameter logic [9:0] V_FP     = DEF_V_FP,
    parameter logic [9:0] V_SYNC   = DEF_V_SYNC,
    parameter logic [9:0] V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [2:0] shape_color,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       de,
    output logic       frame_start
);

    localparam logic [9:0] LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] FRAME_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] HS_FIRST    = H_ACTIVE + H_FP;
    localparam logic [9:0] HS_LAST     = H_ACTIVE + H_FP + H_SYNC - 10'd1;
    localparam logic [9:0] VS_FIRST    = V_ACTIVE + V_FP;
    localparam logic [9:0] VS_LAST     = V_ACTIVE + V_FP + V_SYNC - 10'd1;

    logic [9:0] h;
    logic [9:0] v;
    logic       h_wrap;
    logic       v_wrap;

    scan_counter #(.TOTAL(LINE_TOTAL)) u_h_count (
        .clk   (clk),
        .rst   (rst),
        .en    (pix_en),
        .count (h),
        .wrap  (h_wrap)
    );

    scan_counter #(.TOTAL(FRAME_TOTAL)) u_v_count (
        .clk   (clk),
        .rst   (rst),
        .en    (h_wrap),
        .count (v),
        .wrap  (v_wrap)
    );

    assign x = h;
    assign y = v;

    logic   active;
    color_t pix_color;
    color_t rgb_d;
    logic   hsync_d;
    logic   vsync_d;
    logic   frame_start_d;

    color_t rgb_q;
    logic   de_q;
    logic   hsync_q;
    logic   vsync_q;
    logic   frame_start_q;
    // Registered "counters sit at (0,0)": set by the frame wrap instead of a 20-bit compare.
    logic   origin_q;

    always_comb begin
        active    = (h < H_ACTIVE) && (v < V_ACTIVE);
        pix_color = shape_color;
`ifdef VGA_SCAN_BORDER_EN
        if (h == '0 || h == H_ACTIVE - 10'd1 || v == '0 || v == V_ACTIVE - 10'd1) begin
            pix_color = COLOR_WHITE;
        end
`endif
        rgb_d         = active ? pix_color : COLOR_BLACK;
        hsync_d       = !((h >= HS_FIRST) && (h <= HS_LAST));
        vsync_d       = !((v >= VS_FIRST) && (v <= VS_LAST));
        frame_start_d = pix_en && origin_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q         <= COLOR_BLACK;
            de_q          <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            origin_q      <= 1'b1;
        end else begin
            // Not gated by pix_en so the pulse lasts one clk even with a slow strobe.
            frame_start_q <= frame_start_d;
            if (pix_en) begin
                rgb_q    <= rgb_d;
                de_q     <= active;
                hsync_q  <= hsync_d;
                vsync_q  <= vsync_d;
                origin_q <= v_wrap;
            end
        end
    end

    assign red         = rgb_q[COLOR_R];
    assign green       = rgb_q[COLOR_G];
    assign blue        = rgb_q[COLOR_B];
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench: a default-timing instance for 640x480 line timing and a reduced-timing
// instance (32x19 total) so full frames, throttling and resets run in a few thousand cycles.
module tb_vga_scan_driver;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;
    logic sc_mode;

    logic [2:0] sc_b;
    logic [9:0] xb, yb;
    logic       hsb, vsb, rb, gb, bb, deb, fsb;

    logic [2:0] sc_s;
    logic [9:0] xs, ys;
    logic       hss, vss, rs, gs, bs, des, fss;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign sc_b = 3'b100;
    assign sc_s = sc_mode ? {xs[0], ys[0], 1'b1} : 3'b100;

    vga_scan_driver u_big (
        .clk(clk), .rst(rst), .pix_en(pix_en), .shape_color(sc_b),
        .x(xb), .y(yb), .hsync(hsb), .vsync(vsb),
        .red(rb), .green(gb), .blue(bb), .de(deb), .frame_start(fsb)
    );

    vga_scan_driver #(
        .H_ACTIVE(10'd16), .H_FP(10'd4), .H_SYNC(10'd6), .H_BP(10'd6),
        .V_ACTIVE(10'd12), .V_FP(10'd2), .V_SYNC(10'd2), .V_BP(10'd3)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pix_en), .shape_color(sc_s),
        .x(xs), .y(ys), .hsync(hss), .vsync(vss),
        .red(rs), .green(gs), .blue(bs), .de(des), .frame_start(fss)
    );

    // Small-instance expectation for the pixel registered from scan position s:
    // {rgb[2:0], de, hsync, vsync, frame_start}. hsync low h in [20,25], vsync low v in [14,15].
    function automatic logic [6:0] s_exp(input int s, input bit alt);
        int hh;
        int vv;
        logic act;
        logic [2:0] c;
        hh  = s % 32;
        vv  = (s / 32) % 19;
        act = (hh < 16) && (vv < 12);
        c   = !act ? 3'b000 : (alt ? {1'(hh % 2), 1'(vv % 2), 1'b1} : 3'b100);
        return {c, act, !(hh >= 20 && hh <= 25), !(vv >= 14 && vv <= 15), (hh == 0 && vv == 0)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        pix_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pix_en = 1'b1;
        sc_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({xb, yb, hsb, vsb, rb, gb, bb, deb, fsb} !== {20'd0, 2'b11, 5'b0}) begin
                miscompares++;
                $display("FAIL reset_big cyc=%0d got x=%0d y=%0d hs=%b vs=%b rgb=%b%b%b de=%b fs=%b want zeros with hs=vs=1",
                         i, xb, yb, hsb, vsb, rb, gb, bb, deb, fsb);
            end
            vectors++;
            if ({xs, ys, hss, vss, rs, gs, bs, des, fss} !== {20'd0, 2'b11, 5'b0}) begin
                miscompares++;
                $display("FAIL reset_small cyc=%0d got x=%0d y=%0d hs=%b vs=%b rgb=%b%b%b de=%b fs=%b want zeros with hs=vs=1",
                         i, xs, ys, hss, vss, rs, gs, bs, des, fss);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_line_timing();
        int rgb_cnt = 0;
        int hs_cnt = 0;
        int hs_first = -1;
        int hh;
        logic act;
        logic [6:0] exp_o;
        for (int n = 1; n <= 1600; n++) begin
            @(posedge clk); #1;
            hh  = (n - 1) % 800;
            act = hh < 640;
            vectors++;
            if ({xb, yb} !== {10'(n % 800), 10'(n / 800)}) begin
                miscompares++;
                $display("FAIL line_xy n=%0d got x=%0d y=%0d want x=%0d y=%0d", n, xb, yb, n % 800, n / 800);
            end
            exp_o = {act ? 3'b100 : 3'b000, act, !(hh >= 656 && hh <= 751), 1'b1, n == 1};
            vectors++;
            if ({rb, gb, bb, deb, hsb, vsb, fsb} !== exp_o) begin
                miscompares++;
                $display("FAIL line_out n=%0d got %b want %b", n, {rb, gb, bb, deb, hsb, vsb, fsb}, exp_o);
            end
            if (n <= 800) begin
                if ({rb, gb, bb} == 3'b100) rgb_cnt++;
                if (!hsb) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = hh;
                end
            end
        end
        vectors++;
        if (rgb_cnt != 640) begin
            miscompares++;
            $display("FAIL line_rgb_count got %0d want 640", rgb_cnt);
        end
        vectors++;
        if (hs_cnt != 96) begin
            miscompares++;
            $display("FAIL line_hsync_width got %0d want 96", hs_cnt);
        end
        vectors++;
        if (hs_first != 656) begin
            miscompares++;
            $display("FAIL line_hsync_start got %0d want 656", hs_first);
        end
    endtask

    task automatic test_frame_wrap();
        int fs_cnt = 0;
        int vs_cnt = 0;
        int vs_first = -1;
        logic [6:0] exp_o;
        do_reset();
        sc_mode = 1'b0;
        for (int n = 1; n <= 1216; n++) begin
            @(posedge clk); #1;
            vectors++;
            if ({xs, ys} !== {10'(n % 32), 10'((n / 32) % 19)}) begin
                miscompares++;
                $display("FAIL frame_xy n=%0d got x=%0d y=%0d want x=%0d y=%0d", n, xs, ys, n % 32, (n / 32) % 19);
            end
            exp_o = s_exp(n - 1, 1'b0);
            vectors++;
            if ({rs, gs, bs, des, hss, vss, fss} !== exp_o) begin
                miscompares++;
                $display("FAIL frame_out n=%0d got %b want %b", n, {rs, gs, bs, des, hss, vss, fss}, exp_o);
            end
            if (fss) fs_cnt++;
            if (!vss) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = n - 1;
            end
        end
        vectors++;
        if (fs_cnt != 2) begin
            miscompares++;
            $display("FAIL frame_start_count got %0d want 2", fs_cnt);
        end
        vectors++;
        if (vs_cnt != 128) begin
            miscompares++;
            $display("FAIL frame_vsync_width got %0d want 128", vs_cnt);
        end
        vectors++;
        if (vs_first != 448) begin
            miscompares++;
            $display("FAIL frame_vsync_start got %0d want 448", vs_first);
        end
    endtask

    task automatic test_throttle();
        int k = 0;
        int fs_cnt = 0;
        logic [6:0] exp_o;
        do_reset();
        sc_mode = 1'b0;
        for (int c = 0; c < 4 * 610; c++) begin
            pix_en = (c % 4 == 0);
            @(posedge clk); #1;
            if (pix_en) k++;
            vectors++;
            if ({xs, ys} !== {10'(k % 32), 10'((k / 32) % 19)}) begin
                miscompares++;
                $display("FAIL throttle_xy c=%0d got x=%0d y=%0d want x=%0d y=%0d", c, xs, ys, k % 32, (k / 32) % 19);
            end
            exp_o = s_exp(k - 1, 1'b0);
            exp_o[0] = exp_o[0] && pix_en;
            vectors++;
            if ({rs, gs, bs, des, hss, vss, fss} !== exp_o) begin
                miscompares++;
                $display("FAIL throttle_out c=%0d got %b want %b", c, {rs, gs, bs, des, hss, vss, fss}, exp_o);
            end
            if (fss) fs_cnt++;
        end
        pix_en = 1'b1;
        vectors++;
        if (fs_cnt != 2) begin
            miscompares++;
            $display("FAIL throttle_fs_count got %0d want 2", fs_cnt);
        end
    endtask

    task automatic test_alignment();
        logic [6:0] exp_o;
        do_reset();
        sc_mode = 1'b1;
        for (int n = 1; n <= 608; n++) begin
            @(posedge clk); #1;
            exp_o = s_exp(n - 1, 1'b1);
            vectors++;
            if ({rs, gs, bs, des} !== exp_o[6:3]) begin
                miscompares++;
                $display("FAIL align_rgb n=%0d got rgb=%b%b%b de=%b want rgb=%b de=%b",
                         n, rs, gs, bs, des, exp_o[6:4], exp_o[3]);
            end
        end
        sc_mode = 1'b0;
    endtask

    task automatic test_mid_frame_reset();
        do_reset();
        sc_mode = 1'b0;
        repeat (170) @(posedge clk);
        #1;
        vectors++;
        if ({xs, ys} !== {10'd10, 10'd5}) begin
            miscompares++;
            $display("FAIL midrst_pre got x=%0d y=%0d want x=10 y=5", xs, ys);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({xs, ys, hss, vss, rs, gs, bs, des, fss} !== {20'd0, 2'b11, 5'b0}) begin
            miscompares++;
            $display("FAIL midrst_small got x=%0d y=%0d hs=%b vs=%b rgb=%b%b%b de=%b fs=%b want reset values",
                     xs, ys, hss, vss, rs, gs, bs, des, fss);
        end
        vectors++;
        if ({xb, yb, hsb, vsb, rb, gb, bb, deb, fsb} !== {20'd0, 2'b11, 5'b0}) begin
            miscompares++;
            $display("FAIL midrst_big got x=%0d y=%0d hs=%b vs=%b rgb=%b%b%b de=%b fs=%b want reset values",
                     xb, yb, hsb, vsb, rb, gb, bb, deb, fsb);
        end
        @(posedge clk); #1;
        vectors++;
        if ({xs, ys, rs, gs, bs, des, hss, vss, fss} !== {10'd1, 10'd0, 3'b100, 4'b1111}) begin
            miscompares++;
            $display("FAIL midrst_resume got x=%0d y=%0d rgb=%b%b%b de=%b hs=%b vs=%b fs=%b want x=1 y=0 rgb=100 de=1 hs=1 vs=1 fs=1",
                     xs, ys, rs, gs, bs, des, hss, vss, fss);
        end
        @(posedge clk); #1;
        vectors++;
        if ({xs, fss} !== {10'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_fs_pulse got x=%0d fs=%b want x=2 fs=0", xs, fss);
        end
    endtask

    initial begin
        rst = 1'b1;
        pix_en = 1'b1;
        sc_mode = 1'b0;
        test_reset();
        test_line_timing();
        test_frame_wrap();
        test_throttle();
        test_alignment();
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Raster scan driver for the 640×480 display path. It generates the pixel coordinates `x`/`y` that the shape and colour generators consume, and accepts their 3-bit `shape_color` in return. It then masks blanking, aligns colour with the sync pulses through one register stage, and drives the VGA connector pins. It sits between the pixel-rate clock enable and the board's RGB/sync outputs.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `clk`  in  1  system clock; one clock domain only
- `rst`  in  1  synchronous, active-high reset
- `pix_en`  in  1  pixel-rate strobe; all state advances only when high (may be tied high)
- `shape_color`  in  3  colour for the current `x`/`y`; [2]=R, [1]=G, [0]=B; combinational return from the generator
- `x`  out  10  current horizontal count, 0..H_TOTAL-1
- `y`  out  10  current vertical count, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `red`, `green`, `blue`  out  1 each  pixel colour, aligned with syncs
- `de`  out  1  display enable, aligned with RGB
- `frame_start`  out  1  one-`clk` pulse when the pixel at (0,0) is presented on RGB

## Operation
- `H_TOTAL` is the sum of the four horizontal parameters (800). `V_TOTAL` is the sum of the four vertical parameters (525). Both must be ≤ 1024 so they fit 10-bit counters.
- Horizontal counter `h`:
  - increments on each `pix_en`;
  - at `H_TOTAL-1` it wraps to 0 and asserts the line-wrap event.
- Vertical counter `v`:
  - increments on each line-wrap event;
  - at `V_TOTAL-1` it wraps to 0 in the same `pix_en` cycle as `h` wraps.
- `x` = `h` and `y` = `v`, driven directly from the counter registers. Coordinates continue counting through blanking; downstream blocks must tolerate `x` ≥ 640 and `y` ≥ 480.
- `active` = (`h` < `H_ACTIVE`) && (`v` < `V_ACTIVE`), computed from the current counters.
- Output stage, registered on `pix_en`:
  - `{red,green,blue}` ← `active ? shape_color : 3'b000`
  - `de` ← `active`
  - `hsync` ← ~(`h` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. [656,751]
  - `vsync` ← ~(`v` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), i.e. [490,491]
  - `frame_start` ← (`h`==0 && `v`==0)
- `frame_start` is qualified so it stays high for exactly one `clk` cycle, even when `pix_en` is tied high.
- Reset values:
  - `x`=0, `y`=0
  - `hsync`=1, `vsync`=1
  - `red`=`green`=`blue`=0
  - `de`=0, `frame_start`=0
- Reset asserted mid-frame: all outputs return to their reset values on the next `clk` edge. The scan restarts at (0,0) on the first `pix_en` after `rst` deasserts.
- `pix_en` low: every register holds its value; no event is lost or repeated.

## Timing
- Coordinate to pixel latency: exactly one `pix_en`-qualified stage. The colour for coordinate (`x`,`y`) appears on RGB after the next `pix_en` edge, together with that coordinate's `hsync`/`vsync`/`de`.
- `shape_color` must settle within the same `clk` cycle as `x`/`y`; it is sampled only on `pix_en`.
- Period of 800 pixels per line and 525 lines per frame; 420 000 `pix_en` strobes per frame.
- Pulse widths at defaults:
  - `hsync` low for 96 pixels per line;
  - `vsync` low for 2 full lines (1600 pixels).

## Configuration
- `VGA_SCAN_BORDER_EN` defined: within the active region, any pixel with `h`∈{0, H_ACTIVE-1} or `v`∈{0, V_ACTIVE-1} outputs `3'b111`, overriding `shape_color`. Used for monitor alignment.
- Macro undefined: no override logic is built and RGB follows `shape_color` only.

## Structure
- Package `vga_pkg` holds:
  - the default timing constants and the derived `H_TOTAL`/`V_TOTAL`;
  - the `color_t` typedef (logic [2:0]);
  - the named bit indices `COLOR_R`=2, `COLOR_G`=1, `COLOR_B`=0;
  - the shared colour constants `COLOR_BLACK`, `COLOR_WHITE`, `COLOR_RED` and `COLOR_BLUE`.
- Sub-module `scan_counter`: parameter `TOTAL`; ports `clk`, `rst`, `en`, `count[9:0]`, `wrap`. It is instantiated twice:
  - horizontal instance: `en`=`pix_en`;
  - vertical instance: `en`=`pix_en` && `h_wrap`.

## Test plan
- **Reset hold:** `rst`=1 for 5 cycles with `pix_en`=1 → `x`=`y`=0, `hsync`=`vsync`=1, RGB=0, `de`=0 throughout.
- **Line timing:** `pix_en` tied high, `shape_color`=3'b100 → RGB=100 for exactly 640 cycles per line, `hsync` low for 96 cycles starting 656 cycles after the first active pixel (counter value 656), line period 800 cycles.
- **Frame wrap:** run one full frame → `y` goes 524→0 on the same edge as `x` goes 799→0; `vsync` low during lines 490–491 only; `frame_start` high for exactly 1 cycle per 420 000.
- **Enable throttle:** `pix_en` high one cycle in four → every output period scales ×4; RGB/sync never change on cycles where `pix_en`=0.
- **Alignment:** `shape_color` driven as `{x[0],y[0],1'b1}` → the RGB registered at each edge equals the function of the previous cycle's `x`/`y`; RGB=000 whenever `x` ≥ 640 or `y` ≥ 480.
- **Mid-frame reset:** assert `rst` at `x`=300, `y`=200 for 1 cycle → the next edge gives reset values; after release, scan resumes at (0,0) and the first `frame_start` follows one stage later.
